// File: rtl/pwm_multi.sv
// NCH-channel PWM with one shared prescaler and timebase, edge- or centre-aligned counting.
// Define PWM_DEADTIME_EN to add complementary outputs with per-channel dead-time insertion.
module pwm_multi #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 10,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned DT_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [DIV_W-1:0]     clkdiv,
    input  logic [CNT_W-1:0]     period,
    input  logic [NCH*CNT_W-1:0] cmp,
    input  logic                 load,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]      dead,
    output logic [NCH-1:0]       pwm_out_n,
`endif
    output logic [NCH-1:0]       pwm_out,
    output logic                 period_tick,
    output logic [CNT_W-1:0]     cnt_out
);

    logic                 en_q;
    logic                 run, start, tick, wrap, up_mode;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dir_q, dir_d;  // 1 = counting down
    logic [CNT_W-1:0]     period_sh_q, period_act_q;
    logic [NCH*CNT_W-1:0] cmp_sh_q, cmp_act_q;
    logic [NCH-1:0]       raw, pwm_d, pwm_q;
    logic                 period_tick_q;

    // The cycle en rises only reloads the active set; counting begins the cycle after.
    assign run     = en & en_q;
    assign start   = en & ~en_q;
    assign tick    = run & (div_q >= clkdiv);
    assign up_mode = ~mode | (period_act_q == '0);

    always_comb begin
        div_d = '0;
        cnt_d = '0;
        dir_d = 1'b0;
        if (run) begin
            div_d = tick ? '0 : div_q + 1'b1;
            cnt_d = cnt_q;
            dir_d = dir_q;
            if (tick) begin
                if (up_mode) begin
                    dir_d = 1'b0;
                    cnt_d = (cnt_q == period_act_q) ? '0 : cnt_q + 1'b1;
                end else if (!dir_q) begin
                    if (cnt_q == period_act_q) begin
                        dir_d = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        dir_d = 1'b0;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        end
    end

    // Only the period-start tick can land the count on zero.
    assign wrap = tick & (cnt_d == '0);

    always_comb begin
        raw = '0;
        for (int i = 0; i < NCH; i++) begin
            raw[i] = cnt_q < cmp_act_q[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            div_q         <= '0;
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            period_sh_q   <= '0;
            period_act_q  <= '0;
            cmp_sh_q      <= '0;
            cmp_act_q     <= '0;
            pwm_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            en_q          <= en;
            div_q         <= div_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            pwm_q         <= pwm_d;
            period_tick_q <= wrap;
            if (load) begin
                period_sh_q <= period;
                cmp_sh_q    <= cmp;
            end
            // A load landing on the reload point bypasses the shadows.
            if (start || wrap) begin
                period_act_q <= load ? period : period_sh_q;
                cmp_act_q    <= load ? cmp : cmp_sh_q;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [NCH-1:0] pwm_n_d, pwm_n_q;

    for (genvar i = 0; i < NCH; i++) begin : g_dt
        logic            prev_q;
        logic [DT_W-1:0] len, len_q, len_d;

        // len = cycles raw has already held its current value, saturating.
        assign len        = (raw[i] == prev_q) ? len_q : '0;
        assign len_d      = (len == {DT_W{1'b1}}) ? len : len + 1'b1;
        assign pwm_d[i]   = run & raw[i] & (len >= dead);
        assign pwm_n_d[i] = run & ~raw[i] & (len >= dead);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= 1'b0;
                len_q  <= '0;
            end else if (run) begin
                prev_q <= raw[i];
                len_q  <= len_d;
            end else begin
                prev_q <= 1'b0;
                len_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_n_q <= '0;
        else        pwm_n_q <= pwm_n_d;
    end

    assign pwm_out_n = pwm_n_q;
`else
    assign pwm_d = run ? raw : '0;
`endif

    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;
    assign cnt_out     = cnt_q;

endmodule
